sdram_arbiter_n: RTL and testbench
==================================

Name: sdram_arbiter_n

Overview:
- N-client arbiter for the single 128-bit SDRAM bridge (22-bit word address, 16-bit byte enable).
- Clients are the SD-card loader, sprite/line-buffer writers, DFJK background drawer and I2S audio fetcher.
- Generalises the fixed-client arbiter: parametrised client count, selectable fixed-priority or round-robin mode, an urgent-client class, and a watchdog timeout on bridge acknowledge.
- One transaction in flight; sits between all clients and sdram_contorller's bridge port.

Parameters:
N_CLIENTS, 6, number of client ports (2..16)
ADDR_W, 22, client/bridge word address width
DATA_W, 128, data width
BE_W, 16, byte-enable width (DATA_W/8)
RR_MODE, 1, 1 = round-robin among equal class, 0 = fixed priority (lowest index wins)
URGENT_MASK, 6'b010000, clients in mask always beat non-urgent clients
TIMEOUT_CYC, 1023, cycles to wait for bridge acknowledge; 0 disables watchdog

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  synchronous active-low reset
cli_rd  in  N_CLIENTS  per-client read request, held until cli_ac
cli_wr  in  N_CLIENTS  per-client write request, held until cli_ac
cli_addr  in  N_CLIENTS*ADDR_W  packed addresses, client i at [i*ADDR_W +: ADDR_W]
cli_wrdata  in  N_CLIENTS*DATA_W  packed write data
cli_be  in  N_CLIENTS*BE_W  packed byte enables
cli_wait  out  N_CLIENTS  high = request not yet being serviced
cli_ac  out  N_CLIENTS  one-cycle completion pulse
cli_rddata  out  DATA_W  registered read data, broadcast, valid while cli_ac high
bridge_address  out  ADDR_W  to bridge (top level appends 4'b0000)
bridge_byte_enable  out  BE_W
bridge_read  out  1
bridge_write  out  1
bridge_write_data  out  DATA_W
bridge_acknowledge  in  1
bridge_read_data  in  DATA_W
grant_id  out  $clog2(N_CLIENTS)  index of the client being serviced
busy  out  1  state != IDLE
timeout_err  out  1  sticky, set on any watchdog expiry
err_id  out  $clog2(N_CLIENTS)  client index of the first timeout

Behaviour:
- Reset (reset_n low at clk edge): state IDLE; all outputs 0 except cli_wait = all ones; rr pointer = N_CLIENTS-1; timeout_err = 0; err_id = 0. Reset mid-transaction drops the bridge command immediately and issues no ac.
- req[i] = cli_rd[i] | cli_wr[i]. If both are high, the request is treated as a write.
- IDLE: if any req is high, select a winner, register grant_id, address, be, wrdata and op, then go to ISSUE. Otherwise stay.
- Selection:
  - candidate set = urgent requesters if any, else all requesters.
  - RR_MODE = 1: first candidate at index > rr pointer, wrapping modulo N; the pointer updates to the winner.
  - RR_MODE = 0: lowest candidate index.
- ISSUE: bridge_read or bridge_write held high with registered address, be and data. Watchdog counter increments each cycle.
  - On bridge_acknowledge: deassert the command, capture bridge_read_data into cli_rddata (reads only), go to DONE.
  - If the counter reaches TIMEOUT_CYC first: deassert the command; set timeout_err, and set err_id if not already set; go to DONE. cli_rddata is left unchanged.
- DONE: cli_ac[grant_id] = 1 for exactly one cycle, then return to IDLE.
- Latency: requests sampled in IDLE at cycle 0; bridge command from cycle 1; acknowledge at cycle k gives ac at cycle k+1. Minimum IDLE-to-IDLE is 3 cycles (ack in cycle 1).
- cli_wait[i] = 0 only while state is ISSUE or DONE and grant_id == i; otherwise 1.
- Clients must drop their request at the edge after seeing ac, so the following IDLE never re-grants a stale request.
- Requests arriving during ISSUE or DONE are not lost; they are evaluated at the next IDLE.
- Acknowledge outside ISSUE is ignored.
- Inputs of the granted client may change after the IDLE edge without effect, since all command fields are registered.

Decomposition:
- Package sdram_arb_pkg: state enum (IDLE, ISSUE, DONE), default ADDR_W/DATA_W/BE_W constants.
- Sub-module arb_pick: combinational priority picker with inputs req vector, urgent mask, rr pointer and mode; outputs winner index and valid. Reused by future bus arbiters.

Test Plan:
- Single read: client 2 reads addr 22'h01234, bridge acks in cycle 3 with data 128'hA5 repeated -> bridge_read high cycles 1-3, cli_ac[2] pulses in cycle 4, cli_rddata = A5 pattern, cli_wait[2] low in cycles 1-4.
- Round-robin: RR_MODE = 1, clients 0, 1 and 3 hold requests, bridge acks immediately -> grant order 0, 1, 3, 0, each period 3 cycles.
- Urgent: client 4 (urgent) requests while clients 0 and 1 are pending and client 0 is in ISSUE -> client 0 completes, then 4 is granted before 1.
- Fixed mode: RR_MODE = 0, clients 1 and 5 request continuously -> client 1 granted every time, client 5 starves with cli_wait[5] = 1.
- Timeout: TIMEOUT_CYC = 8, no acknowledge for client 3 -> command drops after 8 cycles, cli_ac[3] pulses, timeout_err = 1, err_id = 3; a later client-0 read completes normally and timeout_err stays 1.
- Reset mid-ISSUE: reset_n low during client-2 write -> next cycle bridge_write = 0, no ac pulse, cli_wait all ones; after release, pending requests are served from rr pointer N-1 (client 0 first).

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared constants for the SDRAM bridge arbiter: default bus widths and FSM state codes.
package sdram_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 22;
   localparam int unsigned DATA_W_DEF = 128;
   localparam int unsigned BE_W_DEF   = 16;

   // Arbiter FSM states; kept as plain constants so legacy code can compare raw codes.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/sdram_arbiter_n_if.sv
// Bridge-side bus of the SDRAM arbiter.
//   master : arbiter drives the command (address, byte enable, read/write, write data)
//   slave  : SDRAM controller bridge returns acknowledge and read data
interface sdram_bridge_if
   import sdram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned BE_W   = BE_W_DEF
);

   logic [ADDR_W-1:0] bridge_address;
   logic [BE_W-1:0]   bridge_byte_enable;
   logic              bridge_read;
   logic              bridge_write;
   logic [DATA_W-1:0] bridge_write_data;
   logic              bridge_acknowledge;
   logic [DATA_W-1:0] bridge_read_data;

   modport master (
      output bridge_address, bridge_byte_enable, bridge_read, bridge_write, bridge_write_data,
      input  bridge_acknowledge, bridge_read_data
   );

   modport slave (
      input  bridge_address, bridge_byte_enable, bridge_read, bridge_write, bridge_write_data,
      output bridge_acknowledge, bridge_read_data
   );

endinterface

// File: rtl/arb_pick.sv
// Combinational priority picker.
//   req      : request vector
//   urgent   : urgent-class mask; urgent requesters shadow all others
//   ptr      : round-robin pointer (last winner)
//   rr_mode  : 1 = first candidate after ptr (wrapping), 0 = lowest index
//   winner_c : selected index, valid_c : any candidate present
module arb_pick #(
   parameter int unsigned N = 6,
   parameter int unsigned W = 3
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] urgent,
   input  logic [W-1:0] ptr,
   input  logic         rr_mode,
   output logic [W-1:0] winner_c,
   output logic         valid_c
);

   logic [N-1:0] cand;
   logic [W-1:0] pos;
   logic         found;

   always_comb begin
      cand     = ((req & urgent) != '0) ? (req & urgent) : req;
      valid_c  = |cand;
      winner_c = '0;
      pos      = '0;
      found    = 1'b0;
      if (rr_mode) begin
         // Scan ptr+1 .. ptr+N so the last winner has the lowest priority.
         for (int k = 1; k <= int'(N); k++) begin
            pos = W'((int'(ptr) + k) % int'(N));
            if (!found && cand[pos]) begin
               winner_c = pos;
               found    = 1'b1;
            end
         end
      end else begin
         for (int k = int'(N) - 1; k >= 0; k--) begin
            if (cand[W'(k)]) winner_c = W'(k);
         end
      end
   end

endmodule

// File: rtl/sdram_arbiter_n.sv
// N-client arbiter in front of the single 128-bit SDRAM bridge; one transaction in flight.
//   clk, reset_n            : clock, synchronous active-low reset
//   cli_rd/cli_wr           : per-client requests (write wins when both high), held until cli_ac
//   cli_addr/wrdata/be      : packed per-client command fields
//   cli_wait/cli_ac         : per-client wait flag and one-cycle completion pulse
//   cli_rddata              : read data broadcast, valid with cli_ac
//   bridge                  : command/ack bus to the SDRAM controller bridge
//   grant_id/busy           : current grant and non-idle flag
//   timeout_err/err_id      : sticky watchdog error and first offending client
module sdram_arbiter_n
   import sdram_arb_pkg::*;
#(
   parameter int unsigned          N_CLIENTS   = 6,
   parameter int unsigned          ADDR_W      = ADDR_W_DEF,
   parameter int unsigned          DATA_W      = DATA_W_DEF,
   parameter int unsigned          BE_W        = BE_W_DEF,
   parameter bit                   RR_MODE     = 1'b1,
   parameter logic [N_CLIENTS-1:0] URGENT_MASK = 6'b010000,
   parameter int unsigned          TIMEOUT_CYC = 1023
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [N_CLIENTS-1:0]            cli_rd,
   input  logic [N_CLIENTS-1:0]            cli_wr,
   input  logic [N_CLIENTS*ADDR_W-1:0]     cli_addr,
   input  logic [N_CLIENTS*DATA_W-1:0]     cli_wrdata,
   input  logic [N_CLIENTS*BE_W-1:0]       cli_be,
   output logic [N_CLIENTS-1:0]            cli_wait,
   output logic [N_CLIENTS-1:0]            cli_ac,
   output logic [DATA_W-1:0]               cli_rddata,
   sdram_bridge_if.master                  bridge,
   output logic [$clog2(N_CLIENTS)-1:0]    grant_id,
   output logic                            busy,
   output logic                            timeout_err,
   output logic [$clog2(N_CLIENTS)-1:0]    err_id
);

   localparam int unsigned ID_W  = $clog2(N_CLIENTS);
   localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

   logic [1:0]           state_q, state_d;
   logic [ID_W-1:0]      rr_q, rr_d, gnt_d, eid_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [BE_W-1:0]      be_q, be_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d, rddata_d;
   logic                 rd_q, rd_d, wr_q, wr_d, busy_d, terr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [N_CLIENTS-1:0] req_c, ac_d, wait_d;
   logic [ID_W-1:0]      pick_c;
   logic                 pick_valid_c;

   assign req_c = cli_rd | cli_wr;

   arb_pick #(.N(N_CLIENTS), .W(ID_W)) u_pick (
      .req      (req_c),
      .urgent   (URGENT_MASK),
      .ptr      (rr_q),
      .rr_mode  (RR_MODE),
      .winner_c (pick_c),
      .valid_c  (pick_valid_c)
   );

   assign bridge.bridge_address     = addr_q;
   assign bridge.bridge_byte_enable = be_q;
   assign bridge.bridge_read        = rd_q;
   assign bridge.bridge_write       = wr_q;
   assign bridge.bridge_write_data  = wdata_q;

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      gnt_d    = grant_id;
      rr_d     = rr_q;
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      cnt_d    = cnt_q;
      rddata_d = cli_rddata;
      terr_d   = timeout_err;
      eid_d    = err_id;
      ac_d     = '0;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid_c) begin
               gnt_d   = pick_c;
               rr_d    = pick_c;
               addr_d  = cli_addr[int'(pick_c)*int'(ADDR_W) +: ADDR_W];
               be_d    = cli_be[int'(pick_c)*int'(BE_W) +: BE_W];
               wdata_d = cli_wrdata[int'(pick_c)*int'(DATA_W) +: DATA_W];
               wr_d    = cli_wr[pick_c];
               rd_d    = !cli_wr[pick_c];
               cnt_d   = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bridge.bridge_acknowledge) begin
               rd_d           = 1'b0;
               wr_d           = 1'b0;
               if (rd_q) rddata_d = bridge.bridge_read_data;
               ac_d[grant_id] = 1'b1;
               state_d        = ST_DONE;
            end else if ((TIMEOUT_CYC != 0) && (cnt_d == CNT_W'(TIMEOUT_CYC))) begin
               // Watchdog: abandon the command and still complete the client.
               rd_d           = 1'b0;
               wr_d           = 1'b0;
               terr_d         = 1'b1;
               if (!timeout_err) eid_d = grant_id;
               ac_d[grant_id] = 1'b1;
               state_d        = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
      wait_d = '1;
      if (state_d != ST_IDLE) wait_d[gnt_d] = 1'b0;
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         grant_id    <= '0;
         rr_q        <= ID_W'(N_CLIENTS - 1);
         addr_q      <= '0;
         be_q        <= '0;
         wdata_q     <= '0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         cnt_q       <= '0;
         cli_rddata  <= '0;
         cli_ac      <= '0;
         cli_wait    <= '1;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         err_id      <= '0;
      end else begin
         state_q     <= state_d;
         grant_id    <= gnt_d;
         rr_q        <= rr_d;
         addr_q      <= addr_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         cnt_q       <= cnt_d;
         cli_rddata  <= rddata_d;
         cli_ac      <= ac_d;
         cli_wait    <= wait_d;
         busy        <= busy_d;
         timeout_err <= terr_d;
         err_id      <= eid_d;
      end
   end

endmodule

// File: tb/tb_sdram_arbiter_n.sv
// Directed bench: a round-robin instance and a fixed-priority instance share client stimulus.
module tb_sdram_arbiter_n;

   localparam int unsigned N  = 6;
   localparam int unsigned AW = 22;
   localparam int unsigned DW = 128;
   localparam int unsigned BW = 16;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [N-1:0]      cli_rd, cli_wr;
   logic [N*AW-1:0]   cli_addr;
   logic [N*DW-1:0]   cli_wrdata;
   logic [N*BW-1:0]   cli_be;
   logic              ack;
   logic [DW-1:0]     rdata;

   logic [N-1:0]      rr_wait, rr_ac, fx_wait, fx_ac;
   logic [DW-1:0]     rr_rddata, fx_rddata;
   logic [2:0]        rr_gid, rr_eid, fx_gid, fx_eid;
   logic              rr_busy, rr_terr, fx_busy, fx_terr;

   int checks   = 0;
   int failures = 0;

   always #10 clk = ~clk;

   sdram_bridge_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) br_rr ();
   sdram_bridge_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) br_fx ();

   assign br_rr.bridge_acknowledge = ack;
   assign br_rr.bridge_read_data   = rdata;
   assign br_fx.bridge_acknowledge = ack;
   assign br_fx.bridge_read_data   = rdata;

   sdram_arbiter_n #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .RR_MODE(1'b1),
                     .URGENT_MASK(6'b010000), .TIMEOUT_CYC(8)) dut_rr (
      .clk(clk), .reset_n(reset_n), .cli_rd(cli_rd), .cli_wr(cli_wr), .cli_addr(cli_addr),
      .cli_wrdata(cli_wrdata), .cli_be(cli_be), .cli_wait(rr_wait), .cli_ac(rr_ac),
      .cli_rddata(rr_rddata), .bridge(br_rr), .grant_id(rr_gid), .busy(rr_busy),
      .timeout_err(rr_terr), .err_id(rr_eid)
   );

   sdram_arbiter_n #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .RR_MODE(1'b0),
                     .URGENT_MASK(6'b010000), .TIMEOUT_CYC(8)) dut_fx (
      .clk(clk), .reset_n(reset_n), .cli_rd(cli_rd), .cli_wr(cli_wr), .cli_addr(cli_addr),
      .cli_wrdata(cli_wrdata), .cli_be(cli_be), .cli_wait(fx_wait), .cli_ac(fx_ac),
      .cli_rddata(fx_rddata), .bridge(br_fx), .grant_id(fx_gid), .busy(fx_busy),
      .timeout_err(fx_terr), .err_id(fx_eid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      cli_rd = '0; cli_wr = '0; cli_addr = '0; cli_wrdata = '0; cli_be = '0;
      ack = 1'b0; rdata = '0;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      clear_inputs();
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clear_inputs();
      tick();
      tick();
      checks++; if (rr_wait !== 6'b111111) begin failures++; $display("FAIL reset_wait got=%b exp=111111", rr_wait); end
      checks++; if (rr_ac !== 6'b000000) begin failures++; $display("FAIL reset_ac got=%b exp=000000", rr_ac); end
      checks++; if (br_rr.bridge_read !== 1'b0 || br_rr.bridge_write !== 1'b0) begin failures++; $display("FAIL reset_cmd got=%b%b exp=00", br_rr.bridge_read, br_rr.bridge_write); end
      checks++; if (rr_gid !== 3'd0 || rr_busy !== 1'b0) begin failures++; $display("FAIL reset_gid_busy got=%0d/%b exp=0/0", rr_gid, rr_busy); end
      checks++; if (rr_terr !== 1'b0 || rr_eid !== 3'd0) begin failures++; $display("FAIL reset_err got=%b/%0d exp=0/0", rr_terr, rr_eid); end
      checks++; if (rr_rddata !== '0) begin failures++; $display("FAIL reset_rddata got=%h exp=0", rr_rddata); end
      reset_n = 1'b1;
   endtask

   task automatic test_single_read();
      apply_reset();
      cli_rd = 6'b000100;
      cli_addr[2*AW +: AW] = 22'h01234;
      tick(); // cycle 1
      checks++; if (br_rr.bridge_read !== 1'b1 || br_rr.bridge_write !== 1'b0) begin failures++; $display("FAIL sr_cmd_c1 got=%b%b exp=10", br_rr.bridge_read, br_rr.bridge_write); end
      checks++; if (br_rr.bridge_address !== 22'h01234) begin failures++; $display("FAIL sr_addr got=%h exp=01234", br_rr.bridge_address); end
      checks++; if (rr_gid !== 3'd2 || rr_busy !== 1'b1) begin failures++; $display("FAIL sr_gid got=%0d/%b exp=2/1", rr_gid, rr_busy); end
      checks++; if (rr_wait !== 6'b111011) begin failures++; $display("FAIL sr_wait_c1 got=%b exp=111011", rr_wait); end
      tick(); // cycle 2
      checks++; if (br_rr.bridge_read !== 1'b1) begin failures++; $display("FAIL sr_rd_c2 got=%b exp=1", br_rr.bridge_read); end
      tick(); // cycle 3
      checks++; if (br_rr.bridge_read !== 1'b1 || rr_ac !== 6'b0) begin failures++; $display("FAIL sr_c3 got=%b/%b exp=1/000000", br_rr.bridge_read, rr_ac); end
      ack = 1'b1;
      rdata = {16{8'hA5}};
      tick(); // cycle 4
      checks++; if (rr_ac !== 6'b000100) begin failures++; $display("FAIL sr_ac got=%b exp=000100", rr_ac); end
      checks++; if (rr_rddata !== {16{8'hA5}}) begin failures++; $display("FAIL sr_rddata got=%h exp=a5..a5", rr_rddata); end
      checks++; if (br_rr.bridge_read !== 1'b0 || rr_wait !== 6'b111011) begin failures++; $display("FAIL sr_c4 got=%b/%b exp=0/111011", br_rr.bridge_read, rr_wait); end
      ack = 1'b0;
      rdata = '0;
      cli_rd = '0;
      tick(); // cycle 5
      checks++; if (rr_ac !== 6'b0 || rr_wait !== 6'b111111 || rr_busy !== 1'b0) begin failures++; $display("FAIL sr_c5 got=%b/%b/%b exp=000000/111111/0", rr_ac, rr_wait, rr_busy); end
      checks++; if (rr_rddata !== {16{8'hA5}}) begin failures++; $display("FAIL sr_rddata_hold got=%h exp=a5..a5", rr_rddata); end
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_id [4];
      exp_id = '{3'd0, 3'd1, 3'd3, 3'd0};
      apply_reset();
      ack = 1'b1;
      cli_rd = 6'b001011;
      for (int k = 0; k < 4; k++) begin
         tick(); // ISSUE
         if (k == 3) cli_rd = '0;
         checks++; if (rr_gid !== exp_id[k] || br_rr.bridge_read !== 1'b1) begin failures++; $display("FAIL rr_grant%0d got=%0d/%b exp=%0d/1", k, rr_gid, br_rr.bridge_read, exp_id[k]); end
         tick(); // DONE
         checks++; if (rr_ac !== 6'(1 << exp_id[k])) begin failures++; $display("FAIL rr_ac%0d got=%b exp=%b", k, rr_ac, 6'(1 << exp_id[k])); end
         tick(); // IDLE
         checks++; if (rr_busy !== 1'b0 || rr_ac !== 6'b0) begin failures++; $display("FAIL rr_idle%0d got=%b/%b exp=0/000000", k, rr_busy, rr_ac); end
      end
      ack = 1'b0;
      tick();
   endtask

   task automatic test_fixed();
      logic [2:0] exp_rr [4];
      exp_rr = '{3'd1, 3'd5, 3'd1, 3'd5};
      apply_reset();
      ack = 1'b1;
      cli_rd = 6'b100010;
      for (int k = 0; k < 4; k++) begin
         tick(); // ISSUE
         if (k == 3) cli_rd = '0;
         checks++; if (fx_gid !== 3'd1 || fx_wait !== 6'b111101) begin failures++; $display("FAIL fx_grant%0d got=%0d/%b exp=1/111101", k, fx_gid, fx_wait); end
         checks++; if (rr_gid !== exp_rr[k]) begin failures++; $display("FAIL fx_rr_alt%0d got=%0d exp=%0d", k, rr_gid, exp_rr[k]); end
         tick(); // DONE
         checks++; if (fx_ac !== 6'b000010 || fx_wait[5] !== 1'b1) begin failures++; $display("FAIL fx_ac%0d got=%b/%b exp=000010/1", k, fx_ac, fx_wait[5]); end
         tick(); // IDLE
      end
      ack = 1'b0;
      tick();
   endtask

   task automatic test_urgent();
      apply_reset();
      cli_rd = 6'b000001;
      tick(); // cycle 1: client 0 in ISSUE
      checks++; if (rr_gid !== 3'd0 || br_rr.bridge_read !== 1'b1) begin failures++; $display("FAIL ur_c1 got=%0d/%b exp=0/1", rr_gid, br_rr.bridge_read); end
      cli_rd = 6'b010011;
      tick(); // cycle 2
      ack = 1'b1;
      tick(); // cycle 3: DONE for client 0
      checks++; if (rr_ac !== 6'b000001 || rr_wait !== 6'b111110) begin failures++; $display("FAIL ur_ac0 got=%b/%b exp=000001/111110", rr_ac, rr_wait); end
      cli_rd = 6'b010010;
      tick(); // cycle 4: IDLE, ack ignored
      checks++; if (rr_ac !== 6'b0 || rr_busy !== 1'b0) begin failures++; $display("FAIL ur_idle got=%b/%b exp=000000/0", rr_ac, rr_busy); end
      tick(); // cycle 5
      checks++; if (rr_gid !== 3'd4) begin failures++; $display("FAIL ur_grant4 got=%0d exp=4", rr_gid); end
      tick(); // cycle 6
      checks++; if (rr_ac !== 6'b010000) begin failures++; $display("FAIL ur_ac4 got=%b exp=010000", rr_ac); end
      cli_rd = 6'b000010;
      tick(); // cycle 7
      tick(); // cycle 8
      checks++; if (rr_gid !== 3'd1) begin failures++; $display("FAIL ur_grant1 got=%0d exp=1", rr_gid); end
      tick(); // cycle 9
      checks++; if (rr_ac !== 6'b000010) begin failures++; $display("FAIL ur_ac1 got=%b exp=000010", rr_ac); end
      cli_rd = '0;
      ack = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      apply_reset();
      cli_wr = 6'b001000;
      cli_addr[3*AW +: AW]   = 22'h3ABCD;
      cli_wrdata[3*DW +: DW] = {4{32'hDEADBEEF}};
      cli_be[3*BW +: BW]     = 16'h00FF;
      tick(); // cycle 1
      checks++; if (br_rr.bridge_write !== 1'b1 || br_rr.bridge_read !== 1'b0) begin failures++; $display("FAIL to_cmd got=%b%b exp=01", br_rr.bridge_read, br_rr.bridge_write); end
      checks++; if (br_rr.bridge_write_data !== {4{32'hDEADBEEF}} || br_rr.bridge_byte_enable !== 16'h00FF) begin failures++; $display("FAIL to_data got=%h/%h exp=deadbeef../00ff", br_rr.bridge_write_data, br_rr.bridge_byte_enable); end
      cli_addr[3*AW +: AW] = 22'h00001;
      cli_be[3*BW +: BW]   = 16'hFFFF;
      for (int c = 2; c <= 8; c++) begin
         tick();
         checks++; if (br_rr.bridge_write !== 1'b1 || rr_ac !== 6'b0) begin failures++; $display("FAIL to_hold_c%0d got=%b/%b exp=1/000000", c, br_rr.bridge_write, rr_ac); end
      end
      checks++; if (br_rr.bridge_address !== 22'h3ABCD || br_rr.bridge_byte_enable !== 16'h00FF || rr_terr !== 1'b0) begin failures++; $display("FAIL to_c8 got=%h/%h/%b exp=3abcd/00ff/0", br_rr.bridge_address, br_rr.bridge_byte_enable, rr_terr); end
      tick(); // cycle 9
      checks++; if (br_rr.bridge_write !== 1'b0 || rr_ac !== 6'b001000) begin failures++; $display("FAIL to_drop got=%b/%b exp=0/001000", br_rr.bridge_write, rr_ac); end
      checks++; if (rr_terr !== 1'b1 || rr_eid !== 3'd3) begin failures++; $display("FAIL to_err got=%b/%0d exp=1/3", rr_terr, rr_eid); end
      cli_wr = '0;
      tick(); // cycle 10 IDLE
      cli_rd = 6'b000001;
      tick(); // cycle 11 ISSUE
      ack = 1'b1;
      rdata = {8{16'h5A3C}};
      tick(); // cycle 12 DONE
      checks++; if (rr_ac !== 6'b000001 || rr_rddata !== {8{16'h5A3C}}) begin failures++; $display("FAIL to_read0 got=%b/%h exp=000001/5a3c..", rr_ac, rr_rddata); end
      checks++; if (rr_terr !== 1'b1 || rr_eid !== 3'd3) begin failures++; $display("FAIL to_sticky got=%b/%0d exp=1/3", rr_terr, rr_eid); end
      cli_rd = '0;
      ack = 1'b0;
      tick();
      cli_wr = 6'b100000;
      for (int c = 1; c <= 9; c++) tick();
      checks++; if (rr_ac !== 6'b100000 || rr_eid !== 3'd3 || rr_terr !== 1'b1) begin failures++; $display("FAIL to_second got=%b/%0d/%b exp=100000/3/1", rr_ac, rr_eid, rr_terr); end
      cli_wr = '0;
      tick();
   endtask

   task automatic test_reset_mid_issue();
      apply_reset();
      cli_wr = 6'b000100;
      cli_addr[2*AW +: AW] = 22'h00777;
      tick(); // cycle 1
      checks++; if (br_rr.bridge_write !== 1'b1 || rr_gid !== 3'd2) begin failures++; $display("FAIL rm_c1 got=%b/%0d exp=1/2", br_rr.bridge_write, rr_gid); end
      cli_rd = 6'b001001;
      tick(); // cycle 2
      reset_n = 1'b0;
      tick(); // cycle 3
      checks++; if (br_rr.bridge_write !== 1'b0 || rr_ac !== 6'b0) begin failures++; $display("FAIL rm_drop got=%b/%b exp=0/000000", br_rr.bridge_write, rr_ac); end
      checks++; if (rr_wait !== 6'b111111 || rr_busy !== 1'b0) begin failures++; $display("FAIL rm_wait got=%b/%b exp=111111/0", rr_wait, rr_busy); end
      reset_n = 1'b1;
      tick(); // cycle 4
      checks++; if (rr_gid !== 3'd0 || br_rr.bridge_read !== 1'b1 || rr_ac !== 6'b0) begin failures++; $display("FAIL rm_restart got=%0d/%b/%b exp=0/1/000000", rr_gid, br_rr.bridge_read, rr_ac); end
      ack = 1'b1;
      tick(); // cycle 5
      checks++; if (rr_ac !== 6'b000001) begin failures++; $display("FAIL rm_ac got=%b exp=000001", rr_ac); end
      clear_inputs();
      tick();
      tick();
   endtask

   initial begin
      clear_inputs();
      reset_n = 1'b0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_fixed();
      test_urgent();
      test_timeout();
      test_reset_mid_issue();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
